// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: stall/redirect requests from the pipeline in,
// fetch address, ROM enable, stall vector and flush out.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stall_req_id;
  logic              stall_req_ex;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] exc_pc;
  logic              imem_ready;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic [5:0]        stall;
  logic              flush_out;

  modport master (
    input  stall_req_id, stall_req_ex, branch_flag, branch_target,
    input  flush, exc_pc, imem_ready,
    output pc, ce, stall, flush_out
  );

  modport slave (
    output stall_req_id, stall_req_ex, branch_flag, branch_target,
    output flush, exc_pc, imem_ready,
    input  pc, ce, stall, flush_out
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer and stall arbiter: redirects land on pc one cycle after sampling.
// Stall vector/flush are combinational; pc/ce are registered and hold under stall.
module fetch_ctrl #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  state_t            state_q;
  logic              ce_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              br_pend_q, br_pend_d;
  logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
  logic [5:0]        stall_c;
  logic              flush_c;

  always_comb begin
    stall_c = 6'b000000;
    flush_c = 1'b0;
    if (ce_q) begin
      if (bus.flush)             flush_c = 1'b1;
      else if (bus.stall_req_ex) stall_c = 6'b001111;
      else if (bus.stall_req_id) stall_c = 6'b000111;
      else if (!bus.imem_ready)  stall_c = 6'b000011;
    end
  end

  // An imem-only stall lets ID advance, so a branch resolved then must be parked.
  always_comb begin
    pc_d      = pc_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    if (ce_q) begin
      if (bus.flush) begin
        pc_d      = bus.exc_pc;
        br_pend_d = 1'b0;
      end else if (stall_c[0]) begin
        if (bus.branch_flag && !stall_c[2]) begin
          br_pend_d = 1'b1;
          br_tgt_d  = bus.branch_target;
        end
      end else if (bus.branch_flag) begin
        pc_d      = bus.branch_target;
        br_pend_d = 1'b0;
      end else if (br_pend_q) begin
        pc_d      = br_tgt_q;
        br_pend_d = 1'b0;
      end else begin
        pc_d = pc_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ce_q      <= 1'b0;
      pc_q      <= RESET_VECTOR;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      case (state_q)
        IDLE: begin
          ce_q    <= 1'b1;
          state_q <= RUN;
        end
        RUN:  if (!bus.imem_ready && !bus.flush) state_q <= WAIT;
        WAIT: if (bus.imem_ready || bus.flush)   state_q <= RUN;
        default: begin
          ce_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ce        = ce_q;
  assign bus.stall     = stall_c;
  assign bus.flush_out = flush_c;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, stalls, branches,
// imem wait with parked branch, flush priority, wrap and mid-stream reset.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_ctrl_if #(.ADDR_W(32)) bus ();

  fetch_ctrl #(.ADDR_W(32), .RESET_VECTOR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_req_id  = 1'b0;
    bus.stall_req_ex  = 1'b0;
    bus.branch_flag   = 1'b0;
    bus.branch_target = 32'h0;
    bus.flush         = 1'b0;
    bus.exc_pc        = 32'h0;
    bus.imem_ready    = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.flush        = 1'b1;
    bus.stall_req_ex = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", bus.ce); end
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 000000", bus.stall); end
    n_checks++; if (bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL reset_flush_out: got %b want 0", bus.flush_out); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    idle_inputs();
    rst = 1'b0;
    #1;
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL first_cycle_ce: got %b want 0", bus.ce); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.ce !== 1'b1) begin n_fail++; $display("FAIL seq_ce[%0d]: got %b want 1", i, bus.ce); end
      n_checks++; if (bus.pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, exp_pc[i]); end
    end
    tick();
    n_checks++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL seq_pc_10: got %h want 00000010", bus.pc); end
  endtask

  task automatic test_stall_ex();
    bus.stall_req_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.stall !== 6'b001111) begin n_fail++; $display("FAIL ex_stall[%0d]: got %b want 001111", i, bus.stall); end
      n_checks++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL ex_pc_hold[%0d]: got %h want 00000010", i, bus.pc); end
      tick();
    end
    n_checks++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL ex_pc_after: got %h want 00000010", bus.pc); end
    bus.stall_req_ex = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL ex_resume: got %h want 00000014", bus.pc); end
  endtask

  task automatic test_stall_id();
    bus.stall_req_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // Last stalled cycle also carries a branch that ID keeps; it must not be parked.
      if (i == 2) begin
        bus.branch_flag   = 1'b1;
        bus.branch_target = 32'h900;
      end
      #1;
      n_checks++; if (bus.stall !== 6'b000111) begin n_fail++; $display("FAIL id_stall[%0d]: got %b want 000111", i, bus.stall); end
      n_checks++; if (bus.pc !== 32'h14) begin n_fail++; $display("FAIL id_pc_hold[%0d]: got %h want 00000014", i, bus.pc); end
      tick();
    end
    bus.stall_req_id = 1'b0;
    bus.branch_flag  = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'h18) begin n_fail++; $display("FAIL id_resume_no_park: got %h want 00000018", bus.pc); end
  endtask

  task automatic test_branch();
    tick();
    tick();
    n_checks++; if (bus.pc !== 32'h20) begin n_fail++; $display("FAIL br_start: got %h want 00000020", bus.pc); end
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h400;
    #1;
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL br_stall: got %b want 000000", bus.stall); end
    tick();
    n_checks++; if (bus.pc !== 32'h400) begin n_fail++; $display("FAIL br_target: got %h want 00000400", bus.pc); end
    bus.branch_flag = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'h404) begin n_fail++; $display("FAIL br_next: got %h want 00000404", bus.pc); end
  endtask

  task automatic test_imem_wait_branch();
    bus.imem_ready = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 6'b000011) begin n_fail++; $display("FAIL wait_stall0: got %b want 000011", bus.stall); end
    tick();
    n_checks++; if (bus.pc !== 32'h404) begin n_fail++; $display("FAIL wait_hold0: got %h want 00000404", bus.pc); end
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'h800;
    #1;
    n_checks++; if (bus.stall !== 6'b000011) begin n_fail++; $display("FAIL wait_stall1: got %b want 000011", bus.stall); end
    tick();
    n_checks++; if (bus.pc !== 32'h404) begin n_fail++; $display("FAIL wait_hold1: got %h want 00000404", bus.pc); end
    bus.branch_flag = 1'b0;
    bus.imem_ready  = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL wait_release_stall: got %b want 000000", bus.stall); end
    tick();
    n_checks++; if (bus.pc !== 32'h800) begin n_fail++; $display("FAIL wait_pending_br: got %h want 00000800", bus.pc); end
    tick();
    n_checks++; if (bus.pc !== 32'h804) begin n_fail++; $display("FAIL wait_after_br: got %h want 00000804", bus.pc); end
  endtask

  task automatic test_flush();
    bus.imem_ready    = 1'b0;
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'hA00;
    tick();
    bus.branch_flag  = 1'b0;
    bus.flush        = 1'b1;
    bus.exc_pc       = 32'h180;
    bus.stall_req_ex = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 6'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 000000", bus.stall); end
    n_checks++; if (bus.flush_out !== 1'b1) begin n_fail++; $display("FAIL flush_out_hi: got %b want 1", bus.flush_out); end
    tick();
    n_checks++; if (bus.pc !== 32'h180) begin n_fail++; $display("FAIL flush_pc: got %h want 00000180", bus.pc); end
    idle_inputs();
    #1;
    n_checks++; if (bus.flush_out !== 1'b0) begin n_fail++; $display("FAIL flush_out_lo: got %b want 0", bus.flush_out); end
    tick();
    n_checks++; if (bus.pc !== 32'h184) begin n_fail++; $display("FAIL flush_drop_pend: got %h want 00000184", bus.pc); end
  endtask

  task automatic test_wrap_and_reset();
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'hFFFF_FFF8;
    tick();
    bus.branch_flag = 1'b0;
    tick();
    n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre: got %h want fffffffc", bus.pc); end
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 00000000", bus.pc); end
    tick();
    bus.imem_ready    = 1'b0;
    bus.branch_flag   = 1'b1;
    bus.branch_target = 32'hC00;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL midrst_pc: got %h want 00000000", bus.pc); end
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL midrst_ce: got %b want 0", bus.ce); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.ce !== 1'b1 || bus.pc !== 32'h0) begin n_fail++; $display("FAIL midrst_refetch: got ce=%b pc=%h want ce=1 pc=00000000", bus.ce, bus.pc); end
    tick();
    n_checks++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL midrst_no_pend: got %h want 00000004", bus.pc); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall_ex();
    test_stall_id();
    test_branch();
    test_imem_wait_branch();
    test_flush();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
